// File: rtl/top.sv
// rtl/top.sv - speed/gear gauge controller: button events, speed, servo gauge, LEDs, 7-seg scan
// Divider, button edge detection, speed/gauge datapath and display scanning in one file.

module clk_div #(
    parameter int HALF_10K = 5000,
    parameter int HALF_1K  = 50000
) (
    input  logic clk_100mhz,
    input  logic rst,
    output logic clk_10khz,
    output logic clk_1khz,
    output logic o_tick_10k,
    output logic o_tick_1k
);
    localparam int W10 = (HALF_10K > 1) ? $clog2(HALF_10K) : 1;
    localparam int W1  = (HALF_1K  > 1) ? $clog2(HALF_1K)  : 1;

    logic [W10-1:0] r_cnt_10k;
    logic [W1-1:0]  r_cnt_1k;
    logic           r_clk_10k;
    logic           r_clk_1k;
    logic           w_wrap_10k;
    logic           w_wrap_1k;

    assign w_wrap_10k = (r_cnt_10k == W10'(HALF_10K - 1));
    assign w_wrap_1k  = (r_cnt_1k  == W1'(HALF_1K - 1));

    always_ff @(posedge clk_100mhz or posedge rst) begin
        if (rst) begin
            r_cnt_10k <= '0;
            r_clk_10k <= 1'b0;
        end else if (w_wrap_10k) begin
            r_cnt_10k <= '0;
            r_clk_10k <= ~r_clk_10k;
        end else begin
            r_cnt_10k <= r_cnt_10k + 1'b1;
        end
    end

    always_ff @(posedge clk_100mhz or posedge rst) begin
        if (rst) begin
            r_cnt_1k <= '0;
            r_clk_1k <= 1'b0;
        end else if (w_wrap_1k) begin
            r_cnt_1k <= '0;
            r_clk_1k <= ~r_clk_1k;
        end else begin
            r_cnt_1k <= r_cnt_1k + 1'b1;
        end
    end

    assign clk_10khz = r_clk_10k;
    assign clk_1khz  = r_clk_1k;
    // Ticks mark the cycle whose edge raises the divided clock.
    assign o_tick_10k = w_wrap_10k & ~r_clk_10k;
    assign o_tick_1k  = w_wrap_1k  & ~r_clk_1k;
endmodule

module top #(
    parameter int HALF_10K = 5000,
    parameter int HALF_1K  = 50000
) (
    input  logic       clk_100mhz,
    input  logic       rst_btn,
    input  logic       btn_accel,
    input  logic       btn_decel,
    input  logic [2:0] gear_sw,
    output logic       servo_pwm,
    output logic [3:0] fnd_sel,
    output logic [7:0] fnd_seg,
    output logic [7:0] leds
);
    logic       w_tick_10k;
    logic       w_tick_1k;
    logic       w_clk_10khz;
    logic       w_clk_1khz;

    logic [1:0] r_acc_sync;
    logic [1:0] r_dec_sync;
    logic       r_acc_prev;
    logic       r_dec_prev;
    logic       w_acc_ev;
    logic       w_dec_ev;

    logic [3:0] r_speed;
    logic [3:0] w_max;
    logic [8:0] w_scaled;
    logic [8:0] w_quot;
    logic [4:0] w_target;
    logic [7:0] r_pwm_cnt;
    logic [4:0] r_gauge;

    logic [1:0] r_scan;
    logic [3:0] w_digit;
    logic       w_blank;
    logic [2:0] w_rgb;

    clk_div #(.HALF_10K(HALF_10K), .HALF_1K(HALF_1K)) u_clk_div (
        .clk_100mhz (clk_100mhz),
        .rst        (rst_btn),
        .clk_10khz  (w_clk_10khz),
        .clk_1khz   (w_clk_1khz),
        .o_tick_10k (w_tick_10k),
        .o_tick_1k  (w_tick_1k)
    );

    always_ff @(posedge clk_100mhz or posedge rst_btn) begin
        if (rst_btn) begin
            r_acc_sync <= 2'b00;
            r_dec_sync <= 2'b00;
            r_acc_prev <= 1'b0;
            r_dec_prev <= 1'b0;
        end else begin
            r_acc_sync <= {r_acc_sync[0], btn_accel};
            r_dec_sync <= {r_dec_sync[0], btn_decel};
            if (w_tick_1k) begin
                r_acc_prev <= r_acc_sync[1];
                r_dec_prev <= r_dec_sync[1];
            end
        end
    end

    assign w_acc_ev = w_tick_1k & r_acc_sync[1] & ~r_acc_prev;
    assign w_dec_ev = w_tick_1k & r_dec_sync[1] & ~r_dec_prev;

    always_comb begin
        w_max = 4'd0;
        case (gear_sw)
            3'd1:    w_max = 4'd3;
            3'd2:    w_max = 4'd5;
            3'd3:    w_max = 4'd7;
            3'd4:    w_max = 4'd11;
            3'd5:    w_max = 4'd15;
            default: w_max = 4'd0;
        endcase
    end

    // A gear downshift clamps first; button events are ignored on that tick.
    always_ff @(posedge clk_100mhz or posedge rst_btn) begin
        if (rst_btn) begin
            r_speed <= 4'd0;
        end else if (w_tick_1k) begin
            if (r_speed > w_max)
                r_speed <= w_max;
            else if (w_acc_ev && !w_dec_ev && r_speed < w_max)
                r_speed <= r_speed + 4'd1;
            else if (w_dec_ev && !w_acc_ev && r_speed != 4'd0)
                r_speed <= r_speed - 4'd1;
        end
    end

    assign w_scaled = 9'(r_speed) * 9'd20;
    assign w_quot   = (w_max == 4'd0) ? 9'd0 : (w_scaled / 9'(w_max));
    assign w_target = 5'd5 + w_quot[4:0];

    always_ff @(posedge clk_100mhz or posedge rst_btn) begin
        if (rst_btn) begin
            r_pwm_cnt <= 8'd0;
            r_gauge   <= 5'd5;
        end else if (w_tick_10k) begin
            if (r_pwm_cnt == 8'd199) begin
                r_pwm_cnt <= 8'd0;
                if (r_gauge < w_target)
                    r_gauge <= r_gauge + 5'd1;
                else if (r_gauge > w_target)
                    r_gauge <= r_gauge - 5'd1;
            end else begin
                r_pwm_cnt <= r_pwm_cnt + 8'd1;
            end
        end
    end

    assign servo_pwm = (r_pwm_cnt < 8'(r_gauge));

    always_comb begin
        w_rgb = 3'b010;
        if (r_speed == w_max && w_max != 4'd0)
            w_rgb = 3'b100;
        else if ({r_speed, 1'b0} > {1'b0, w_max})
            w_rgb = 3'b110;
    end

    assign leds = {w_rgb, r_speed, (r_speed == 4'd0)};

    always_ff @(posedge clk_100mhz or posedge rst_btn) begin
        if (rst_btn)
            r_scan <= 2'd0;
        else if (w_tick_1k)
            r_scan <= r_scan + 2'd1;
    end

    always_comb begin
        w_digit = 4'd0;
        w_blank = 1'b0;
        fnd_sel = 4'b1110;
        case (r_scan)
            2'd0: begin
                fnd_sel = 4'b1110;
                w_digit = (r_speed >= 4'd10) ? (r_speed - 4'd10) : r_speed;
            end
            2'd1: begin
                fnd_sel = 4'b1101;
                w_digit = 4'd1;
                w_blank = (r_speed < 4'd10);
            end
            2'd2: begin
                fnd_sel = 4'b1011;
                w_blank = 1'b1;
            end
            default: begin
                fnd_sel = 4'b0111;
                w_digit = (gear_sw >= 3'd1 && gear_sw <= 3'd5) ? {1'b0, gear_sw} : 4'd0;
            end
        endcase
    end

    // Segment patterns are active low with dp (bit 7) held off.
    always_comb begin
        fnd_seg = 8'hFF;
        if (!w_blank) begin
            case (w_digit)
                4'd0:    fnd_seg = 8'hC0;
                4'd1:    fnd_seg = 8'hF9;
                4'd2:    fnd_seg = 8'hA4;
                4'd3:    fnd_seg = 8'hB0;
                4'd4:    fnd_seg = 8'h99;
                4'd5:    fnd_seg = 8'h92;
                4'd6:    fnd_seg = 8'h82;
                4'd7:    fnd_seg = 8'hF8;
                4'd8:    fnd_seg = 8'h80;
                4'd9:    fnd_seg = 8'h90;
                default: fnd_seg = 8'hFF;
            endcase
        end
    end
endmodule

// File: tb/tb_top.sv
// tb/tb_top.sv - directed scoreboard bench for the gauge controller top
module tb_top;
    logic       clk_100mhz = 1'b0;
    logic       rst_btn    = 1'b1;
    logic       btn_accel  = 1'b0;
    logic       btn_decel  = 1'b0;
    logic [2:0] gear_sw    = 3'd1;
    logic       servo_pwm;
    logic [3:0] fnd_sel;
    logic [7:0] fnd_seg;
    logic [7:0] leds;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        string      tag;
        logic [7:0] val;
    } exp_t;
    exp_t sb[$];

    top #(.HALF_10K(1), .HALF_1K(10)) dut (
        .clk_100mhz (clk_100mhz),
        .rst_btn    (rst_btn),
        .btn_accel  (btn_accel),
        .btn_decel  (btn_decel),
        .gear_sw    (gear_sw),
        .servo_pwm  (servo_pwm),
        .fnd_sel    (fnd_sel),
        .fnd_seg    (fnd_seg),
        .leds       (leds)
    );

    always #5 clk_100mhz = ~clk_100mhz;

    initial begin
        #1_500_000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    task automatic push(input string tag, input logic [7:0] val);
        exp_t e;
        e.tag = tag;
        e.val = val;
        sb.push_back(e);
    endtask

    task automatic check(input logic [7:0] obs);
        exp_t e;
        checks++;
        if (sb.size() == 0) begin
            failures++;
            $display("FAIL scoreboard_empty observed=%0h expected=entry", obs);
        end else begin
            e = sb.pop_front();
            assert (obs === e.val) else begin
                failures++;
                $error("FAIL %s observed=%0h expected=%0h", e.tag, obs, e.val);
            end
        end
    endtask

    task automatic ticks_1k(input int n);
        repeat (n * 20) @(negedge clk_100mhz);
    endtask

    task automatic press(input logic acc, input logic dec);
        @(negedge clk_100mhz);
        btn_accel = acc;
        btn_decel = dec;
        ticks_1k(3);
        btn_accel = 1'b0;
        btn_decel = 1'b0;
        ticks_1k(3);
    endtask

    task automatic settle_periods(input int n);
        repeat (n * 200) @(posedge dut.u_clk_div.clk_10khz);
    endtask

    task automatic measure_servo(output logic [7:0] highs);
        highs = 8'd0;
        repeat (200) begin
            @(posedge dut.u_clk_div.clk_10khz);
            #1;
            if (servo_pwm) highs = highs + 8'd1;
        end
    endtask

    task automatic read_digit(input logic [3:0] sel, output logic [7:0] seg);
        seg = 8'hxx;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk_100mhz);
            if (fnd_sel === sel) begin
                seg = fnd_seg;
                break;
            end
        end
    endtask

    logic [7:0] obs;

    initial begin
        gear_sw = 3'd1;
        rst_btn = 1'b1;
        repeat (10) @(negedge clk_100mhz);
        rst_btn = 1'b0;
        @(negedge clk_100mhz);

        push("reset_leds", 8'b010_0000_1);
        check(leds);
        push("reset_fnd_sel", 8'h0E);
        check({4'h0, fnd_sel});
        push("reset_servo", 8'd5);
        measure_servo(obs);
        check(obs);

        ticks_1k(5);
        push("gear1_idle_leds", 8'h41);
        check(leds);

        repeat (5) press(1'b1, 1'b0);
        push("gear1_sat_leds", 8'h86);
        check(leds);
        settle_periods(21);
        push("gear1_servo", 8'd25);
        measure_servo(obs);
        check(obs);

        gear_sw = 3'd3;
        press(1'b0, 1'b1);
        push("gear3_decel_leds", 8'h44);
        check(leds);
        settle_periods(21);
        push("gear3_servo", 8'd10);
        measure_servo(obs);
        check(obs);

        repeat (2) press(1'b1, 1'b0);
        push("gear3_speed4_leds", 8'hC8);
        check(leds);
        repeat (3) press(1'b1, 1'b0);
        push("gear3_speed7_leds", 8'h8E);
        check(leds);

        gear_sw = 3'd5;
        ticks_1k(2);
        push("gear5_speed7_leds", 8'h4E);
        check(leds);
        gear_sw = 3'd2;
        ticks_1k(2);
        push("gear2_clamp_leds", 8'h8A);
        check(leds);
        press(1'b1, 1'b1);
        push("both_pressed_leds", 8'h8A);
        check(leds);

        push("disp_ones_5", 8'h92);
        read_digit(4'b1110, obs);
        check(obs);
        push("disp_tens_blank", 8'hFF);
        read_digit(4'b1101, obs);
        check(obs);
        push("disp_digit2_blank", 8'hFF);
        read_digit(4'b1011, obs);
        check(obs);
        push("disp_gear_2", 8'hA4);
        read_digit(4'b0111, obs);
        check(obs);

        gear_sw = 3'd0;
        press(1'b1, 1'b0);
        push("neutral_leds", 8'h41);
        check(leds);
        press(1'b0, 1'b1);
        push("neutral_decel_floor", 8'h41);
        check(leds);
        settle_periods(21);
        push("neutral_servo", 8'd5);
        measure_servo(obs);
        check(obs);
        push("disp_gear_neutral", 8'hC0);
        read_digit(4'b0111, obs);
        check(obs);
        push("disp_ones_0", 8'hC0);
        read_digit(4'b1110, obs);
        check(obs);

        gear_sw = 3'd1;
        @(negedge clk_100mhz);
        btn_accel = 1'b1;
        repeat (2) @(negedge clk_100mhz);
        rst_btn = 1'b1;
        ticks_1k(2);
        btn_accel = 1'b0;
        ticks_1k(1);
        rst_btn = 1'b0;
        ticks_1k(4);
        push("reset_midop_leds", 8'h41);
        check(leds);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
